iir_tm_stream_adapter: RTL and testbench

IIR_TM_STREAM_ADAPTER -- requirements
Module: iir_tm_stream_adapter

---
 rtl/iir_tm_stream_adapter_if.sv | 32 +++
 rtl/iir_tm_stream_adapter.sv | 135 +++++++++++++
 tb/tb_iir_tm_stream_adapter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iir_tm_stream_adapter_if.sv
// Stream-side bundle of the IIR time-multiplexed filter adapter: sample in, filter drive/return, result out.
// slave = adapter view, master = environment (source, filter and sink) view.
interface iir_tm_stream_adapter_if #(
    parameter int WIX = 3,
    parameter int WFX = 7,
    parameter int WIO = 8,
    parameter int WFO = 18
);
    logic [WIX+WFX-1:0] S_DATA;
    logic               S_VALID;
    logic               S_READY;
    logic [WIX+WFX-1:0] X;
    logic [WIO+WFO-1:0] Y_IN;
    logic               OVF_IN;
    logic [WIO+WFO-1:0] M_DATA;
    logic               M_VALID;
    logic               M_READY;
    logic               M_OVF;
    logic               BUSY;
    logic               OVF_STICKY;
    logic               OVF_CLR;

    modport slave (
        input  S_DATA, S_VALID, Y_IN, OVF_IN, M_READY, OVF_CLR,
        output S_READY, X, M_DATA, M_VALID, M_OVF, BUSY, OVF_STICKY
    );

    modport master (
        output S_DATA, S_VALID, Y_IN, OVF_IN, M_READY, OVF_CLR,
        input  S_READY, X, M_DATA, M_VALID, M_OVF, BUSY, OVF_STICKY
    );
endinterface

// File: rtl/iir_tm_stream_adapter.sv
// Purpose: holds one sample on X for a time-multiplexed IIR and captures its result; optional IIR_ADAPT_OVF_STICKY_EN.
// Latency: result valid LAT clocks after the accept edge; one sample per LAT+1 clocks sustained.
// Backpressure: a stalled result parks the FSM in HOLD with X frozen; S_READY is low in RUN and HOLD.
module iir_tm_stream_adapter #(
    parameter int NO_SOS = 4,
    parameter int WIX    = 3,
    parameter int WFX    = 7,
    parameter int WIO    = 8,
    parameter int WFO    = 18,
    parameter int LAT    = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    iir_tm_stream_adapter_if.slave  bus
);
    localparam int WX = WIX + WFX;
    localparam int WY = WIO + WFO;
    localparam logic [7:0] LAT_LAST = 8'(LAT - 1);

    if (LAT < 1 || LAT > 255 || NO_SOS < 1) begin : g_bad_params
        $error("iir_tm_stream_adapter: LAT must be 1..255 and NO_SOS at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [7:0]      cnt_q;
    logic [WX-1:0]   x_q;
    logic [WY-1:0]   m_data_q;
    logic            m_ovf_q;
    logic            m_valid_q;
    logic            m_valid_d;
    logic            s_ready_q;
    logic            s_ready_d;
    logic            accept;
    logic            last_cnt;
    logic            out_free;
    logic            capture;

    always_comb begin
        accept    = (state_q == IDLE) && s_ready_q && bus.S_VALID;
        last_cnt  = (cnt_q == LAT_LAST);
        out_free  = !m_valid_q || bus.M_READY;
        capture   = 1'b0;
        state_d   = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_cnt) begin
                    if (out_free) begin
                        capture = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Y_IN is still valid here because X has not moved since the accept.
                if (bus.M_READY) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        m_valid_d = capture || (m_valid_q && !bus.M_READY);
        // Ready is registered from this cycle's M_READY, so a sample may be accepted
        // while the previous result is still stalled; that is the path into HOLD.
        s_ready_d = (state_d == IDLE) && (!m_valid_d || bus.M_READY);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            x_q       <= '0;
            m_data_q  <= '0;
            m_ovf_q   <= 1'b0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
            if (accept) begin
                x_q   <= bus.S_DATA;
                cnt_q <= 8'd0;
            end else if (state_q == RUN && !last_cnt) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (capture) begin
                m_data_q <= bus.Y_IN;
                m_ovf_q  <= bus.OVF_IN;
            end
        end
    end

`ifdef IIR_ADAPT_OVF_STICKY_EN
    logic sticky_q;

    // Set wins over a same-edge clear so an overflow is never lost.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sticky_q <= 1'b0;
        end else if (capture && bus.OVF_IN) begin
            sticky_q <= 1'b1;
        end else if (bus.OVF_CLR) begin
            sticky_q <= 1'b0;
        end
    end

    assign bus.OVF_STICKY = sticky_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = bus.OVF_CLR;
    assign bus.OVF_STICKY = 1'b0;
`endif

    assign bus.S_READY = s_ready_q;
    assign bus.X       = x_q;
    assign bus.M_DATA  = m_data_q;
    assign bus.M_VALID = m_valid_q;
    assign bus.M_OVF   = m_ovf_q;
    assign bus.BUSY    = (state_q == RUN);
endmodule

// File: tb/tb_iir_tm_stream_adapter.sv
// Bench for iir_tm_stream_adapter: vector table plus scoreboard, with hand-written HOLD and reset-abort sequences.
module tb_iir_tm_stream_adapter;
    localparam int NO_SOS = 4;
    localparam int WIX = 3;
    localparam int WFX = 7;
    localparam int WIO = 8;
    localparam int WFO = 18;
    localparam int LAT = 4;
    localparam int WX  = WIX + WFX;
    localparam int WY  = WIO + WFO;
`ifdef IIR_ADAPT_OVF_STICKY_EN
    localparam logic STICKY_EN = 1'b1;
`else
    localparam logic STICKY_EN = 1'b0;
`endif

    typedef struct {
        logic [WX-1:0] s_data;
        logic [WY-1:0] y_in;
        logic          ovf_in;
        logic [WX-1:0] exp_x;
        logic [WY-1:0] exp_m;
        logic          exp_ovf;
    } vec_t;

    typedef struct {
        logic [WY-1:0] m;
        logic          ovf;
    } sb_t;

    logic CLK = 1'b0;
    logic RESET;
    int   errors = 0;
    int   checks = 0;
    sb_t  sb[$];
    vec_t vecs[6];

    always #5 CLK = ~CLK;

    iir_tm_stream_adapter_if #(.WIX(WIX), .WFX(WFX), .WIO(WIO), .WFO(WFO)) bus ();

    iir_tm_stream_adapter #(
        .NO_SOS(NO_SOS), .WIX(WIX), .WFX(WFX), .WIO(WIO), .WFO(WFO), .LAT(LAT)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Simple filter stand-in: re-scale the Q3.7 sample to Q8.18.
    function automatic logic [WY-1:0] yfun(input logic [WX-1:0] s);
        return {{(WIO-WIX){s[WX-1]}}, s, {(WFO-WFX){1'b0}}};
    endfunction

    task automatic sb_check(input string name);
        sb_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: result with empty scoreboard, got 0x%0h", name, bus.M_DATA);
        end else begin
            e = sb.pop_front();
            check({name, "_m_data"}, 64'(bus.M_DATA), 64'(e.m));
            check({name, "_m_ovf"}, 64'(bus.M_OVF), 64'(e.ovf));
        end
    endtask

    task automatic run_one(input vec_t v, input string name);
        int   n;
        int   lat;
        logic saw_rdy;
        bus.S_DATA  = v.s_data;
        bus.S_VALID = 1'b1;
        n = 0;
        while (!bus.S_READY && n < 20) begin
            tick();
            n++;
        end
        if (!bus.S_READY) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: S_READY stayed 0, required 1 within 20 clocks", name);
            bus.S_VALID = 1'b0;
            return;
        end
        tick();
        bus.S_VALID = 1'b0;
        bus.Y_IN    = v.y_in;
        bus.OVF_IN  = v.ovf_in;
        sb.push_back('{v.exp_m, v.exp_ovf});
        check({name, "_busy"}, 64'(bus.BUSY), 64'(1));
        saw_rdy = bus.S_READY;
        lat = 0;
        while (!bus.M_VALID && lat < 300) begin
            tick();
            lat++;
            if (!bus.M_VALID && bus.S_READY) saw_rdy = 1'b1;
        end
        check({name, "_latency"}, 64'(lat), 64'(LAT));
        check({name, "_s_ready_low"}, 64'(saw_rdy), 64'(0));
        check({name, "_x"}, 64'(bus.X), 64'(v.exp_x));
        if (bus.M_VALID) sb_check(name);
        else if (sb.size() > 0) void'(sb.pop_front());
        tick();
        check({name, "_drained"}, 64'(bus.M_VALID), 64'(0));
    endtask

    initial begin
        logic [WX-1:0] bb[4];
        logic [WX-1:0] x_exp;
        logic [WX-1:0] cur;
        logic          will;
        int            acc;
        int            res;
        int            last;
        int            x_bad;
        int            n;
        int            mv_seen;

        vecs[0] = '{10'h040, 26'h0020000, 1'b0, 10'h040, 26'h0020000, 1'b0};
        vecs[1] = '{10'h200, 26'h2000000, 1'b0, 10'h200, 26'h2000000, 1'b0};
        vecs[2] = '{10'h1FF, 26'h1FFFFFF, 1'b0, 10'h1FF, 26'h1FFFFFF, 1'b0};
        vecs[3] = '{10'h3FF, 26'h3FFFFFF, 1'b1, 10'h3FF, 26'h3FFFFFF, 1'b1};
        vecs[4] = '{10'h000, 26'h0000000, 1'b0, 10'h000, 26'h0000000, 1'b0};
        vecs[5] = '{10'h155, 26'h2AAAAAA, 1'b0, 10'h155, 26'h2AAAAAA, 1'b0};
        bb[0] = 10'h011;
        bb[1] = 10'h022;
        bb[2] = 10'h1F0;
        bb[3] = 10'h2CC;

        RESET       = 1'b0;
        bus.S_DATA  = '0;
        bus.S_VALID = 1'b0;
        bus.Y_IN    = '0;
        bus.OVF_IN  = 1'b0;
        bus.M_READY = 1'b1;
        bus.OVF_CLR = 1'b0;

        repeat (3) tick();
        check("rst_s_ready", 64'(bus.S_READY), 64'(0));
        check("rst_x", 64'(bus.X), 64'(0));
        check("rst_m_data", 64'(bus.M_DATA), 64'(0));
        check("rst_m_valid", 64'(bus.M_VALID), 64'(0));
        check("rst_m_ovf", 64'(bus.M_OVF), 64'(0));
        check("rst_busy", 64'(bus.BUSY), 64'(0));
        check("rst_sticky", 64'(bus.OVF_STICKY), 64'(0));
        RESET = 1'b1;
        check("rst_release_s_ready", 64'(bus.S_READY), 64'(0));
        tick();
        check("first_edge_s_ready", 64'(bus.S_READY), 64'(1));

        for (int i = 0; i < 6; i++) begin
            run_one(vecs[i], $sformatf("vec%0d", i));
        end

        check("sticky_after_clean", 64'(bus.OVF_STICKY), 64'(STICKY_EN));
        bus.OVF_CLR = 1'b1;
        tick();
        bus.OVF_CLR = 1'b0;
        check("sticky_cleared", 64'(bus.OVF_STICKY), 64'(0));

        // Back-to-back stream with S_VALID held and M_READY high.
        x_exp = vecs[5].exp_x;
        acc = 0;
        res = 0;
        last = 0;
        x_bad = 0;
        bus.S_DATA  = bb[0];
        bus.S_VALID = 1'b1;
        bus.OVF_IN  = 1'b0;
        for (int c = 0; c < 100 && res < 4; c++) begin
            will = bus.S_VALID && bus.S_READY;
            cur  = bus.S_DATA;
            tick();
            if (will) begin
                x_exp = cur;
                if (acc > 0) check($sformatf("bb_gap%0d", acc), 64'(c - last), 64'(LAT + 1));
                last = c;
                sb.push_back('{yfun(cur), 1'b0});
                bus.Y_IN = yfun(cur);
                acc++;
                if (acc < 4) bus.S_DATA = bb[acc];
                else bus.S_VALID = 1'b0;
            end
            if (bus.X !== x_exp) x_bad++;
            if (bus.M_VALID) begin
                sb_check($sformatf("bb%0d", res));
                res++;
            end
        end
        bus.S_VALID = 1'b0;
        check("bb_results", 64'(res), 64'(4));
        check("bb_x_only_on_accept", 64'(x_bad), 64'(0));

        // Stalled result: second sample lands in HOLD until M_READY rises.
        tick();
        bus.S_DATA  = 10'h0A0;
        bus.S_VALID = 1'b1;
        n = 0;
        while (!bus.S_READY && n < 20) begin
            tick();
            n++;
        end
        tick();
        bus.S_VALID = 1'b0;
        bus.Y_IN    = 26'h1234567;
        sb.push_back('{26'h1234567, 1'b0});
        n = 0;
        while (!bus.M_VALID && n < 20) begin
            tick();
            n++;
        end
        sb_check("hold_a");
        check("hold_a_s_ready", 64'(bus.S_READY), 64'(1));
        bus.M_READY = 1'b0;
        bus.S_DATA  = 10'h0B0;
        bus.S_VALID = 1'b1;
        tick();
        bus.S_VALID = 1'b0;
        bus.Y_IN    = 26'h0BCDEF0;
        sb.push_back('{26'h0BCDEF0, 1'b0});
        check("hold_b_accepted_x", 64'(bus.X), 64'(10'h0B0));
        check("hold_run_busy", 64'(bus.BUSY), 64'(1));
        check("hold_a_kept_valid", 64'(bus.M_VALID), 64'(1));
        repeat (LAT) tick();
        check("hold_busy", 64'(bus.BUSY), 64'(0));
        check("hold_s_ready", 64'(bus.S_READY), 64'(0));
        check("hold_m_valid", 64'(bus.M_VALID), 64'(1));
        check("hold_a_stable", 64'(bus.M_DATA), 64'(26'h1234567));
        repeat (10 - LAT - 1) tick();
        check("hold_a_stable_late", 64'(bus.M_DATA), 64'(26'h1234567));
        bus.M_READY = 1'b1;
        tick();
        check("hold_b_valid", 64'(bus.M_VALID), 64'(1));
        sb_check("hold_b");
        tick();
        check("hold_b_drained", 64'(bus.M_VALID), 64'(0));

        // Reset pulse two clocks into RUN aborts the sample.
        bus.S_DATA  = 10'h0AB;
        bus.S_VALID = 1'b1;
        n = 0;
        while (!bus.S_READY && n < 20) begin
            tick();
            n++;
        end
        tick();
        bus.S_VALID = 1'b0;
        bus.Y_IN    = 26'h3333333;
        bus.OVF_IN  = 1'b1;
        repeat (2) tick();
        #2;
        RESET = 1'b0;
        #1;
        check("abort_x", 64'(bus.X), 64'(0));
        check("abort_m_valid", 64'(bus.M_VALID), 64'(0));
        check("abort_busy", 64'(bus.BUSY), 64'(0));
        check("abort_s_ready", 64'(bus.S_READY), 64'(0));
        tick();
        RESET = 1'b1;
        bus.OVF_IN = 1'b0;
        mv_seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.M_VALID) mv_seen++;
        end
        check("abort_no_output", 64'(mv_seen), 64'(0));
        check("abort_sticky", 64'(bus.OVF_STICKY), 64'(0));
        run_one(vecs[0], "post_reset");

        check("sb_empty_at_end", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
